// File: rtl/convertitore_ad.sv
// ---------------------------------------------------------------------------
// convertitore_ad -- converter (responder) end of a soc/eoc handshake.
// A sample of vin is taken when soc is first seen in IDLE, the conversion
// starts once soc drops, and after CONV_CYCLES clocks the result
// (sample + OFFSET) is presented on x with eoc raised again.
//
// Parameters
//   CONV_CYCLES : conversion length in clock cycles (1..255)
//   OFFSET      : 8-bit unsigned value added to every sample
//
// Build option
//   CONV_SAT_EN : when defined, sums above 'hFF saturate to 'hFF;
//                 otherwise the sum wraps modulo 256.
//
// Ports
//   clock  : sole clock, all state changes on its rising edge
//   reset_ : synchronous reset, active-high
//   soc    : start of conversion from the consumer
//   vin    : 8-bit unsigned sample value
//   eoc    : 1 = x valid / idle, 0 = conversion in progress (registered)
//   x      : 8-bit conversion result (registered)
// ---------------------------------------------------------------------------
module convertitore_ad #(
   parameter int unsigned CONV_CYCLES = 4,
   parameter logic [7:0]  OFFSET      = 8'h00
) (
   input  logic       clock,
   input  logic       reset_,
   input  logic       soc,
   input  logic [7:0] vin,
   output logic       eoc,
   output logic [7:0] x
);

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CONV   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   sample_q, sample_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   x_d;
   logic            eoc_d;
   logic [DW-1:0]   result_c;

   // Result datapath: sample plus offset, saturating or wrapping
`ifdef CONV_SAT_EN
   logic [DW:0] sum_c;
   always_comb begin
      sum_c    = {1'b0, sample_q} + {1'b0, OFFSET};
      result_c = sum_c[DW] ? {DW{1'b1}} : sum_c[DW-1:0];
   end
`else
   always_comb begin
      result_c = sample_q + OFFSET;
   end
`endif

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset_) begin
         state_q  <= IDLE;
         sample_q <= '0;
         cnt_q    <= '0;
         x        <= '0;
         eoc      <= 1'b1;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         cnt_q    <= cnt_d;
         x        <= x_d;
         eoc      <= eoc_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      cnt_d    = cnt_q;
      x_d      = x;
      eoc_d    = eoc;
      case (state_q)
         IDLE: begin
            eoc_d = 1'b1;
            if (soc) begin
               sample_d = vin;
               eoc_d    = 1'b0;
               state_d  = SAMPLE;
            end
         end
         SAMPLE: begin
            eoc_d = 1'b0;
            if (!soc) begin
               cnt_d   = CW'(CONV_CYCLES - 1);
               state_d = CONV;
            end
         end
         CONV: begin
            eoc_d = 1'b0;
            // soc is deliberately ignored here
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               x_d     = result_c;
               eoc_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            eoc_d   = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/convertitore_ad.md
CONVERTITORE_AD -- requirements
Module: convertitore_ad

Interface
REQ-001 Parameter CONV_CYCLES, default 4, conversion length in clock cycles; legal range 1..255.
REQ-002 Parameter OFFSET, default 'H00, 8-bit unsigned value added to every sample.
REQ-003 clock  input  1  sole clock; all state changes on posedge clock.
REQ-004 reset_  input  1  synchronous reset, active-high; sampled on posedge clock only.
REQ-005 soc  input  1  start of conversion, driven by the consumer.
REQ-006 vin  input  8  analog-equivalent sample value, unsigned.
REQ-007 eoc  output  1  end of conversion; 1 = x valid / converter idle, 0 = conversion in progress.
REQ-008 x  output  8  conversion result, unsigned; registered.

Function
REQ-009 The block SHALL be the converter (responder) end of the soc/eoc handshake: idle with eoc=1, eoc drops on soc, eoc rises when x is valid.
REQ-010 The block SHALL implement three states: IDLE, SAMPLE, CONV.
REQ-011 IDLE: eoc=1; on an edge with soc=1, SHALL latch vin into an internal sample register, drive eoc<=0, and go to SAMPLE.
REQ-012 SAMPLE: eoc=0; SHALL stay while soc=1; on an edge with soc=0, SHALL load the cycle counter with CONV_CYCLES-1 and go to CONV.
REQ-013 CONV: eoc=0; each edge with counter!=0 SHALL decrement the counter; the edge with counter==0 SHALL load x with the result, drive eoc<=1, and return to IDLE.
REQ-014 Latency: if soc is first seen low at edge m, eoc SHALL be 1 and x valid after edge m+CONV_CYCLES.
REQ-015 x SHALL hold its value from eoc rise until the next completed conversion; x SHALL NOT change in IDLE, SAMPLE or CONV.
REQ-016 vin SHALL be sampled only at the IDLE->SAMPLE edge; later vin changes SHALL NOT affect the result.
REQ-017 soc changes during CONV SHALL be ignored; soc=1 in IDLE, including soc still high on the return edge, SHALL start a new conversion on the next edge.
REQ-018 Result = sample + OFFSET computed on 9 bits; overflow handling per REQ-022/023.

Reset
REQ-019 On an edge with reset_=1, the block SHALL go to IDLE, set eoc=1, x='H00, counter=0, sample register='H00, overriding all other activity.
REQ-020 Reset during SAMPLE or CONV SHALL abort the conversion; x SHALL read 'H00, not a partial or prior result.
REQ-021 Reset SHALL take priority over soc on the same edge.

Configuration
REQ-022 With macro CONV_SAT_EN defined, a 9-bit sum above 'HFF SHALL saturate x to 'HFF.
REQ-023 Without CONV_SAT_EN, x SHALL be the sum modulo 256: wrap-around, carry discarded.

Verification
REQ-024 Reset, then idle 3 cycles -> eoc=1, x='H00 throughout.
REQ-025 CONV_CYCLES=4, OFFSET=0, vin='H5A, soc high 2 cycles then low at edge m -> eoc=0 from the first soc edge, eoc=1 and x='H5A after edge m+4.
REQ-026 vin changed from 'H10 to 'HF0 one cycle after soc is sampled -> x='H10.
REQ-027 OFFSET='H20, vin='HF0 -> x='HFF with CONV_SAT_EN, x='H10 without it.
REQ-028 reset_=1 at CONV cycle 2 of a conversion of vin='H33 -> eoc=1, x='H00 next edge; a new soc gives a full CONV_CYCLES conversion.
REQ-029 CONV_CYCLES=1, soc pulsed during CONV and held high through the return to IDLE -> no effect during CONV, then a second conversion starts on the first IDLE edge.
